// File: rtl/mul_column_loader_pkg.sv
// -----------------------------------------------------------------------------
// mul_column_loader_pkg
//   Shared types and elaboration-time helpers for mul_column_loader.
//   - state_e     : loader FSM states (ST_PIPE only exists when the
//                   MUL_COLUMN_LOADER_PIPE_EN macro is defined)
//   - col_height  : height of column c of an n x n partial-product matrix
//   - col_offset  : bit offset of column c inside the flattened matrix
// -----------------------------------------------------------------------------
package mul_column_loader_pkg;

`ifdef MUL_COLUMN_LOADER_PIPE_EN
  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PIPE    = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd3
  } state_e;
`endif

  // Column c of an n x n multiplier holds min(c+1, 2n-1-c) partial products.
  function automatic int col_height(input int c, input int n);
    int up;
    int dn;
    up = c + 1;
    dn = 2 * n - 1 - c;
    return (up < dn) ? up : dn;
  endfunction

  // Columns are packed LSB-first, so column c starts after all lower columns.
  function automatic int col_offset(input int c, input int n);
    int off;
    off = 0;
    for (int k = 0; k < c; k++) begin
      off += col_height(k, n);
    end
    return off;
  endfunction

endpackage

// File: rtl/mul_column_loader_column_shifter.sv
// -----------------------------------------------------------------------------
// column_shifter
//   Serial-in / parallel-out register for one matrix column.
//   Parameters:
//     DEPTH      : column height (>= 1)
//   Ports:
//     clk        : clock
//     rst        : asynchronous active-high reset, clears the column
//     shift_en_i : shift one bit in this cycle
//     bit_i      : serial input bit, enters at the LSB
//     q_o        : parallel column contents (LSB = newest bit)
// -----------------------------------------------------------------------------
module column_shifter #(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [DEPTH-1:0] q_o
);

  logic [DEPTH-1:0] q_q;
  logic [DEPTH-1:0] q_d;

  // A height-1 column has nothing to shift; it is simply reloaded.
  generate
    if (DEPTH == 1) begin : g_single
      assign q_d = shift_en_i ? bit_i : q_q;
    end else begin : g_shift
      assign q_d = shift_en_i ? {q_q[DEPTH-2:0], bit_i} : q_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mul_column_loader.sv
// -----------------------------------------------------------------------------
// mul_column_loader
//   Loads an N x N partial-product matrix into per-column shift registers
//   (one serial bit per column per accepted beat), presents the flattened
//   matrix to an external combinational column compressor and captures the
//   compressor's 2N-bit result behind a valid/ready handshake.
//
//   Optional feature: define MUL_COLUMN_LOADER_PIPE_EN to insert a register
//   (dst_q) between the compressor output and `result`, adding a PIPE state.
//
//   Parameters:
//     N          : operand width (2N-1 columns, N*N matrix bits)
//   Ports:
//     clk        : clock
//     rst        : asynchronous active-high reset
//     src_i      : one serial bit per column (bit c feeds column c)
//     in_valid   : a beat is present on src_i
//     in_ready   : loader accepts a beat this cycle (state == FILL)
//     col_bits   : flattened columns, column c at [off(c)+h(c)-1 : off(c)]
//     dst_i      : compressor result, combinational from col_bits
//     result     : captured product (registered)
//     out_valid  : result is valid (registered)
//     out_ready  : consumer takes result
// -----------------------------------------------------------------------------
module mul_column_loader
  import mul_column_loader_pkg::*;
#(
  parameter int N = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*N-2:0]   src_i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*N-1:0]   col_bits,
  input  logic [2*N-1:0]   dst_i,
  output logic [2*N-1:0]   result,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int COLS  = 2 * N - 1;
  localparam int CNT_W = $clog2(N + 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2*N-1:0]   result_q;
  logic [2*N-1:0]   result_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             accept;
  logic             last_beat;

`ifdef MUL_COLUMN_LOADER_PIPE_EN
  logic [2*N-1:0]   dst_q;
  logic [2*N-1:0]   dst_d;
`endif

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (cnt_q == CNT_W'(N - 1));

  // Column registers: one shifter per column, heights follow the diamond shape.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int H   = col_height(c, N);
    localparam int OFF = col_offset(c, N);
    logic [H-1:0] col_q;

    column_shifter #(
      .DEPTH(H)
    ) u_col (
      .clk       (clk),
      .rst       (rst),
      .shift_en_i(accept),
      .bit_i     (src_i[c]),
      .q_o       (col_q)
    );

    assign col_bits[OFF +: H] = col_q;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (last_beat) begin
          state_d = ST_CAPTURE;
        end
      end
`ifdef MUL_COLUMN_LOADER_PIPE_EN
      ST_CAPTURE: state_d = ST_PIPE;
      ST_PIPE:    state_d = ST_HOLD;
`else
      ST_CAPTURE: state_d = ST_HOLD;
`endif
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // FSM outputs: in_ready is decoded from state only, no input feedthrough.
  always_comb begin
    in_ready = (state_q == ST_FILL);
  end

  // Datapath next-state: beat counter, result capture and valid flag.
  always_comb begin
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
`ifdef MUL_COLUMN_LOADER_PIPE_EN
    dst_d       = dst_q;
`endif

    if (accept) begin
      cnt_d = last_beat ? '0 : cnt_q + 1'b1;
    end

`ifdef MUL_COLUMN_LOADER_PIPE_EN
    // Compressor output is registered first, then moved into result.
    if (state_q == ST_CAPTURE) begin
      dst_d = dst_i;
    end
    if (state_q == ST_PIPE) begin
      result_d    = dst_q;
      out_valid_d = 1'b1;
    end
`else
    if (state_q == ST_CAPTURE) begin
      result_d    = dst_i;
      out_valid_d = 1'b1;
    end
`endif

    if ((state_q == ST_HOLD) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef MUL_COLUMN_LOADER_PIPE_EN
      dst_q       <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
`ifdef MUL_COLUMN_LOADER_PIPE_EN
      dst_q       <= dst_d;
`endif
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mul_column_loader.sv
module tb_mul_column_loader;

  localparam int N = 4;
`ifdef MUL_COLUMN_LOADER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  src = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] col_bits;
  logic [7:0]  dst;
  logic [7:0]  result;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_column_loader #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_i    (src),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .col_bits (col_bits),
    .dst_i    (dst),
    .result   (result),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Compressor model: each set bit contributes 2^(its column index).
  function automatic logic [7:0] compress(input logic [15:0] v);
    int colmap [16] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 5, 5, 6};
    int s;
    s = 0;
    for (int b = 0; b < 16; b++) begin
      if (v[b]) s += (1 << colmap[b]);
    end
    return 8'(s);
  endfunction

  assign dst = compress(col_bits);

  task automatic beat(input logic [6:0] s);
    src = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 8'd0) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (col_bits !== 16'h0000) begin failures++; $display("FAIL reset_col_bits got=%h exp=0000", col_bits); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    int lat;
    out_ready = 1'b1;
    repeat (4) beat(7'h7F);
    checks++; if (col_bits !== 16'hFFFF) begin failures++; $display("FAIL ones_col_bits got=%h exp=ffff", col_bits); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ones_early_valid got=%b exp=0", out_valid); end
    wait_out(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL ones_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (result !== 8'd225) begin failures++; $display("FAIL ones_result got=%0d exp=225", result); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ones_valid_clear got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ones_back_to_fill got=%b exp=1", in_ready); end
  endtask

  // Asymmetric beats: checks shift direction and column packing.
  task automatic test_pattern();
    int lat;
    out_ready = 1'b1;
    beat(7'h55);
    beat(7'h2A);
    beat(7'h7F);
    beat(7'h00);
    checks++; if (col_bits !== 16'h4994) begin failures++; $display("FAIL pattern_col_bits got=%h exp=4994", col_bits); end
    wait_out(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL pattern_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (result !== 8'd70) begin failures++; $display("FAIL pattern_result got=%0d exp=70", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc;
    int nout;
    int tout [2];
    logic [7:0] rout [2];
    logic rdy;
    acc = 0;
    nout = 0;
    tout[0] = 0; tout[1] = 0;
    rout[0] = 'x; rout[1] = 'x;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nout < 2; cyc++) begin
      src = (acc < 4) ? 7'h7F : 7'h00;
      in_valid = 1'b1;
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
      if (out_valid) begin
        tout[nout] = cyc;
        rout[nout] = result;
        nout++;
      end
    end
    in_valid = 1'b0;
    checks++; if (nout != 2) begin failures++; $display("FAIL b2b_frames got=%0d exp=2", nout); end
    checks++; if (rout[0] !== 8'd225) begin failures++; $display("FAIL b2b_first_result got=%0d exp=225", rout[0]); end
    checks++; if (rout[1] !== 8'd0) begin failures++; $display("FAIL b2b_second_result got=%0d exp=0", rout[1]); end
    checks++; if (tout[1] - tout[0] != N + 1 + LAT) begin failures++; $display("FAIL b2b_period got=%0d exp=%0d", tout[1] - tout[0], N + 1 + LAT); end
    checks++; if (acc != 8) begin failures++; $display("FAIL b2b_accepted got=%0d exp=8", acc); end
    checks++; if (col_bits !== 16'h0000) begin failures++; $display("FAIL b2b_col_bits got=%h exp=0000", col_bits); end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    int lat;
    out_ready = 1'b0;
    repeat (4) beat(7'h7F);
    wait_out(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL hold_latency got=%0d exp=%0d", lat, LAT); end
    for (int i = 0; i < 5; i++) begin
      src = 7'h00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (result !== 8'd225) begin failures++; $display("FAIL hold_result[%0d] got=%0d exp=225", i, result); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
      checks++; if (col_bits !== 16'hFFFF) begin failures++; $display("FAIL hold_col_bits[%0d] got=%h exp=ffff", i, col_bits); end
    end
    // Release with in_valid still high: that beat must not be taken.
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (col_bits !== 16'hFFFF) begin failures++; $display("FAIL hold_release_col_bits got=%h exp=ffff", col_bits); end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    beat(7'h7F);
    beat(7'h7F);
    rst = 1'b1;
    #2;
    checks++; if (col_bits !== 16'h0000) begin failures++; $display("FAIL rstmid_col_bits got=%h exp=0000", col_bits); end
    checks++; if (result !== 8'd0) begin failures++; $display("FAIL rstmid_result got=%0d exp=0", result); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      beat(7'h01);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_count[%0d] got=%b exp=1", i, in_ready); end
    end
    beat(7'h01);
    checks++; if (col_bits !== 16'h0001) begin failures++; $display("FAIL rstmid_fresh_col_bits got=%h exp=0001", col_bits); end
    wait_out(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (result !== 8'd1) begin failures++; $display("FAIL rstmid_result_fresh got=%0d exp=1", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    int lat;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      beat(7'h7F);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL gaps_in_ready[%0d] got=%b exp=1", b, in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gaps_out_valid[%0d] got=%b exp=0", b, out_valid); end
    end
    beat(7'h7F);
    checks++; if (col_bits !== 16'hFFFF) begin failures++; $display("FAIL gaps_col_bits got=%h exp=ffff", col_bits); end
    wait_out(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL gaps_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (result !== 8'd225) begin failures++; $display("FAIL gaps_result got=%0d exp=225", result); end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_all_ones();
    test_pattern();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
